run_detect_scheduler: RTL and testbench

Time-multiplexed scheduler that shares one run-length detector among N serial bit streams. The detector asserts when the last RUN accepted bits of a stream are all equal (all 0s or all 1s). Requesters present one bit at a time with a req/gnt handshake. A round-robin arbiter picks one bit per cycle, and a per-channel context store lets a single update pipeline serve all channels. It sits between the serial front ends and the downstream event logic, in place of N private detector FSMs.

---
 rtl/run_detect_scheduler_if.sv | 24 ++
 rtl/run_detect_scheduler.sv | 145 ++++++++++++++
 tb/tb_run_detect_scheduler.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/run_detect_scheduler_if.sv
// Requester-side bundle for the shared run-length detector: per-channel
// req/bit/clear in, one-hot grant and a tagged detector result out.
interface run_detect_scheduler_if #(
  parameter int N  = 4,
  parameter int CW = $clog2(N)
);
  logic [N-1:0]  req;
  logic [N-1:0]  w;
  logic [N-1:0]  clr;
  logic [N-1:0]  gnt;
  logic          z_valid;
  logic          z;
  logic [CW-1:0] z_ch;

  modport master (
    output req, w, clr,
    input  gnt, z_valid, z, z_ch
  );

  modport slave (
    input  req, w, clr,
    output gnt, z_valid, z, z_ch
  );
endinterface

// File: rtl/run_detect_scheduler.sv
// One run-length detector time-shared across N serial streams: a round-robin
// arbiter feeds a single update stage that works on a per-channel context.
module run_detect_scheduler #(
  parameter int N   = 4,
  parameter int RUN = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  run_detect_scheduler_if.slave bus
);
  localparam int CW   = $clog2(N);
  localparam int CW1  = CW + 1;
  localparam int CNTW = $clog2(RUN + 1);
  localparam logic [CNTW-1:0] RUN_CNT = CNTW'(RUN);
  localparam logic [CNTW-1:0] ONE_CNT = CNTW'(1);
  localparam logic [CW-1:0]   LAST_CH = CW'(N - 1);
  localparam logic [CW1-1:0]  N_WIDE  = CW1'(N);

  logic [N-1:0]    gnt_q, gnt_d;
  logic [CW-1:0]   ptr_q, ptr_d;
  logic            s1_v_q, s1_v_d;
  logic            s1_bit_q, s1_bit_d;
  logic [CW-1:0]   s1_ch_q, s1_ch_d;
  logic            last_q [N];
  logic            last_d [N];
  logic [CNTW-1:0] cnt_q  [N];
  logic [CNTW-1:0] cnt_d  [N];
  logic            z_valid_q, z_valid_d;
  logic            z_q, z_d;
  logic [CW-1:0]   z_ch_q, z_ch_d;

  logic [N-1:0]    eligible;
  logic            found;
  logic [CW-1:0]   win;
  logic [CW1-1:0]  sum;
  logic [CW-1:0]   idx;
  logic [CNTW-1:0] cur_cnt;
  logic            cur_last;
  logic [CNTW-1:0] upd_cnt;

  // The channel granted last edge is masked so a held req is not consumed twice.
  always_comb begin
    eligible = bus.req & ~gnt_q;
    found    = 1'b0;
    win      = ptr_q;
    sum      = '0;
    idx      = '0;
    for (int off = 0; off < N; off++) begin
      sum = {1'b0, ptr_q} + CW1'(off);
      if (sum >= N_WIDE) begin
        sum = sum - N_WIDE;
      end
      idx = sum[CW-1:0];
      if (!found && eligible[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    gnt_d    = '0;
    s1_v_d   = found;
    s1_bit_d = s1_bit_q;
    s1_ch_d  = s1_ch_q;
    ptr_d    = ptr_q;
    if (found) begin
      gnt_d[win] = 1'b1;
      s1_bit_d   = bus.w[win];
      s1_ch_d    = win;
      ptr_d      = (win == LAST_CH) ? '0 : win + CW'(1);
    end
  end

  // Saturating run count for the channel sitting in the update stage.
  always_comb begin
    cur_cnt  = cnt_q[s1_ch_q];
    cur_last = last_q[s1_ch_q];
    if (cur_cnt == '0 || s1_bit_q != cur_last) begin
      upd_cnt = ONE_CNT;
    end else if (cur_cnt == RUN_CNT) begin
      upd_cnt = RUN_CNT;
    end else begin
      upd_cnt = cur_cnt + ONE_CNT;
    end
  end

  // A clear landing on the same edge as that channel's update takes priority.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      last_d[i] = last_q[i];
      cnt_d[i]  = cnt_q[i];
      if (s1_v_q && s1_ch_q == CW'(i)) begin
        last_d[i] = s1_bit_q;
        cnt_d[i]  = upd_cnt;
      end
      if (bus.clr[i]) begin
        last_d[i] = 1'b0;
        cnt_d[i]  = '0;
      end
    end
    z_valid_d = s1_v_q;
    z_d       = z_q;
    z_ch_d    = z_ch_q;
    if (s1_v_q) begin
      z_d    = (upd_cnt == RUN_CNT) && !bus.clr[s1_ch_q];
      z_ch_d = s1_ch_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_q     <= '0;
      ptr_q     <= '0;
      s1_v_q    <= 1'b0;
      s1_bit_q  <= 1'b0;
      s1_ch_q   <= '0;
      z_valid_q <= 1'b0;
      z_q       <= 1'b0;
      z_ch_q    <= '0;
      for (int i = 0; i < N; i++) begin
        last_q[i] <= 1'b0;
        cnt_q[i]  <= '0;
      end
    end else begin
      gnt_q     <= gnt_d;
      ptr_q     <= ptr_d;
      s1_v_q    <= s1_v_d;
      s1_bit_q  <= s1_bit_d;
      s1_ch_q   <= s1_ch_d;
      z_valid_q <= z_valid_d;
      z_q       <= z_d;
      z_ch_q    <= z_ch_d;
      for (int i = 0; i < N; i++) begin
        last_q[i] <= last_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.z_valid = z_valid_q;
  assign bus.z       = z_q;
  assign bus.z_ch    = z_ch_q;
endmodule

// File: tb/tb_run_detect_scheduler.sv
// Bench for run_detect_scheduler: a cycle table for reset/ch0/clear sequences,
// then a scoreboard for single-channel, full and sparse contention traffic.
module tb_run_detect_scheduler;
  localparam int N   = 4;
  localparam int RUN = 4;
  localparam int CW  = $clog2(N);
  localparam int NROWS = 33;

  logic clk = 1'b0;
  logic reset;

  run_detect_scheduler_if #(.N(N)) bus ();

  run_detect_scheduler #(.N(N), .RUN(RUN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic [N-1:0]  req;
    logic [N-1:0]  w;
    logic [N-1:0]  clr;
    logic [N-1:0]  exp_gnt;
    logic          exp_zv;
    logic          exp_z;
    logic [CW-1:0] exp_zch;
  } vec_t;

  vec_t tbl [NROWS];
  int   errors = 0;
  int   checks = 0;

  bit bit_q [N][$];
  bit exp_z [N][$];
  int exp_gnt [$];

  function automatic vec_t mk(input logic rst, input logic [N-1:0] req, input logic [N-1:0] w,
                              input logic [N-1:0] clr, input logic [N-1:0] eg, input logic ezv,
                              input logic ez, input logic [CW-1:0] ezch);
    vec_t v;
    v.rst = rst; v.req = req; v.w = w; v.clr = clr;
    v.exp_gnt = eg; v.exp_zv = ezv; v.exp_z = ez; v.exp_zch = ezch;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    reset   = v.rst;
    bus.req = v.req;
    bus.w   = v.w;
    bus.clr = v.clr;
  endtask

  task automatic doReset();
    reset   = 1'b1;
    bus.req = '0;
    bus.w   = '0;
    bus.clr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic loadChannel(input int ch, input logic [15:0] bits, input logic [15:0] zs, input int n);
    for (int j = 0; j < n; j++) begin
      bit_q[ch].push_back(bits[j]);
      exp_z[ch].push_back(zs[j]);
    end
  endtask

  // Drives every channel from its bit queue and scores grants and results.
  task automatic runScenario(input string name, input int exp_span, input int budget);
    int first_g, last_g, prev_ch, e;
    bit prev_g, done, pending;
    first_g = -1; last_g = -1; prev_g = 1'b0; prev_ch = 0; done = 1'b0;
    for (int cyc = 0; cyc < budget && !done; cyc++) begin
      for (int i = 0; i < N; i++) begin
        bus.req[i] = (bit_q[i].size() > 0);
        bus.w[i]   = (bit_q[i].size() > 0) ? bit_q[i][0] : 1'b0;
      end
      bus.clr = '0;
      @(posedge clk);
      @(negedge clk);
      checkOutput({name, "_zvalid"}, 32'(bus.z_valid), 32'(prev_g));
      if (bus.z_valid && prev_g) begin
        checkOutput({name, "_zch"}, 32'(bus.z_ch), 32'(prev_ch));
        if (exp_z[prev_ch].size() > 0) begin
          checkOutput($sformatf("%s_z_ch%0d", name, prev_ch), 32'(bus.z), 32'(exp_z[prev_ch].pop_front()));
        end
      end
      prev_g = 1'b0;
      if (bus.gnt != '0) begin
        if (exp_gnt.size() > 0) begin
          e = exp_gnt.pop_front();
          checkOutput({name, "_gnt"}, 32'(bus.gnt), 32'(1) << e);
          prev_g  = 1'b1;
          prev_ch = e;
          if (first_g < 0) first_g = cyc;
          last_g = cyc;
        end else begin
          checkOutput({name, "_gnt_extra"}, 32'(bus.gnt), 32'(0));
        end
        for (int i = 0; i < N; i++) begin
          if (bus.gnt[i] && bit_q[i].size() > 0) void'(bit_q[i].pop_front());
        end
      end
      pending = (exp_gnt.size() > 0);
      for (int i = 0; i < N; i++) begin
        if (bit_q[i].size() > 0) pending = 1'b1;
      end
      done = !pending && !prev_g;
    end
    checkOutput({name, "_finished"}, 32'(done), 32'(1));
    checkOutput({name, "_grant_span"}, 32'(last_g - first_g), 32'(exp_span));
    for (int i = 0; i < N; i++) begin
      checkOutput($sformatf("%s_results_left_ch%0d", name, i), 32'(exp_z[i].size()), 32'(0));
      bit_q[i].delete();
      exp_z[i].delete();
    end
    exp_gnt.delete();
  endtask

  initial begin
    reset   = 1'b1;
    bus.req = '0;
    bus.w   = '0;
    bus.clr = '0;

    // rst, req, w, clr -> gnt, z_valid, z, z_ch
    tbl[0]  = mk(1, 4'hF, 0, 0, 4'h0, 0, 0, 0);
    tbl[1]  = mk(1, 4'hF, 0, 0, 4'h0, 0, 0, 0);
    tbl[2]  = mk(1, 4'hF, 0, 0, 4'h0, 0, 0, 0);
    tbl[3]  = mk(0, 4'hF, 0, 0, 4'h1, 0, 0, 0);
    tbl[4]  = mk(1, 4'h0, 0, 0, 4'h0, 0, 0, 0);
    tbl[5]  = mk(0, 4'h0, 0, 0, 4'h0, 0, 0, 0);
    tbl[6]  = mk(0, 4'h1, 0, 0, 4'h1, 0, 0, 0);
    tbl[7]  = mk(0, 4'h1, 0, 0, 4'h0, 1, 0, 0);
    tbl[8]  = mk(0, 4'h1, 0, 0, 4'h1, 0, 0, 0);
    tbl[9]  = mk(0, 4'h1, 0, 0, 4'h0, 1, 0, 0);
    tbl[10] = mk(0, 4'h1, 0, 0, 4'h1, 0, 0, 0);
    tbl[11] = mk(0, 4'h1, 0, 0, 4'h0, 1, 0, 0);
    tbl[12] = mk(0, 4'h1, 0, 0, 4'h1, 0, 0, 0);
    tbl[13] = mk(0, 4'h1, 0, 0, 4'h0, 1, 1, 0);
    tbl[14] = mk(0, 4'h1, 0, 0, 4'h1, 0, 1, 0);
    tbl[15] = mk(0, 4'h1, 1, 0, 4'h0, 1, 1, 0);
    tbl[16] = mk(0, 4'h1, 1, 0, 4'h1, 0, 1, 0);
    tbl[17] = mk(0, 4'h0, 1, 0, 4'h0, 1, 0, 0);
    tbl[18] = mk(1, 4'h0, 0, 0, 4'h0, 0, 0, 0);
    tbl[19] = mk(0, 4'h1, 0, 0, 4'h1, 0, 0, 0);
    tbl[20] = mk(0, 4'h1, 0, 0, 4'h0, 1, 0, 0);
    tbl[21] = mk(0, 4'h1, 0, 0, 4'h1, 0, 0, 0);
    tbl[22] = mk(0, 4'h1, 0, 0, 4'h0, 1, 0, 0);
    tbl[23] = mk(0, 4'h1, 0, 0, 4'h1, 0, 0, 0);
    tbl[24] = mk(0, 4'h1, 0, 1, 4'h0, 1, 0, 0);
    tbl[25] = mk(0, 4'h1, 0, 0, 4'h1, 0, 0, 0);
    tbl[26] = mk(0, 4'h1, 0, 0, 4'h0, 1, 0, 0);
    tbl[27] = mk(0, 4'h1, 0, 0, 4'h1, 0, 0, 0);
    tbl[28] = mk(0, 4'h1, 0, 0, 4'h0, 1, 0, 0);
    tbl[29] = mk(0, 4'h1, 0, 0, 4'h1, 0, 0, 0);
    tbl[30] = mk(0, 4'h1, 0, 0, 4'h0, 1, 0, 0);
    tbl[31] = mk(0, 4'h1, 0, 0, 4'h1, 0, 0, 0);
    tbl[32] = mk(0, 4'h0, 0, 0, 4'h0, 1, 1, 0);

    @(negedge clk);
    for (int i = 0; i < NROWS; i++) begin
      applyStimulus(tbl[i]);
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("row%0d_gnt", i),  32'(bus.gnt),     32'(tbl[i].exp_gnt));
      checkOutput($sformatf("row%0d_zv", i),   32'(bus.z_valid), 32'(tbl[i].exp_zv));
      checkOutput($sformatf("row%0d_z", i),    32'(bus.z),       32'(tbl[i].exp_z));
      checkOutput($sformatf("row%0d_zch", i),  32'(bus.z_ch),    32'(tbl[i].exp_zch));
    end

    doReset();
    loadChannel(2, 16'h000F, 16'h0088, 8);
    for (int j = 0; j < 8; j++) exp_gnt.push_back(2);
    runScenario("ch2_alone", 14, 60);

    doReset();
    for (int ch = 0; ch < N; ch++) loadChannel(ch, 16'h00FF, 16'h00F8, 8);
    for (int r = 0; r < 8; r++) begin
      for (int ch = 0; ch < N; ch++) exp_gnt.push_back(ch);
    end
    runScenario("full", 31, 80);

    doReset();
    loadChannel(1, 16'h001F, 16'h0018, 6);
    loadChannel(3, 16'h003E, 16'h0030, 6);
    for (int j = 0; j < 6; j++) begin
      exp_gnt.push_back(1);
      exp_gnt.push_back(3);
    end
    runScenario("sparse", 11, 60);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
